lowampa_capture_ctrl: RTL and testbench

Capture sequencer for the low-amplitude trigger datapath, in the `aclk` domain between the beamformed trigger outputs and the capture-buffer streams. It arms capture and enforces a minimum pretrigger dwell. On a qualified beam trigger it runs a fixed-length post-trigger window, then waits for readout and applies a holdoff before re-arming. It also drives the buffer source-select that picks which debug stream (matched, lowpass, square or envelope) feeds the buffers.

---
 rtl/lowampa_capture_ctrl_if.sv | 40 ++++
 rtl/lowampa_capture_ctrl.sv | 154 +++++++++++++++
 tb/tb_lowampa_capture_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lowampa_capture_ctrl_if.sv
// Control/status bundle between the capture sequencer and its host.
// master = host/trigger side, slave = lowampa_capture_ctrl.
interface lowampa_capture_ctrl_if #(
    parameter int NBEAMS   = 2,
    parameter int NSRC     = 4,
    parameter int CNT_BITS = 16
);
    localparam int SRC_BITS = $clog2(NSRC);

    // arm_i/abort_i are one-cycle request pulses with no ready: the sequencer
    // samples them on every aclk edge. capture_waiting_i is a level that the
    // sequencer watches in WAIT. Every output is registered.
    logic                arm_i;
    logic                abort_i;
    logic                auto_rearm_i;
    logic [CNT_BITS-1:0] pre_len_i;
    logic [CNT_BITS-1:0] post_len_i;
    logic [CNT_BITS-1:0] holdoff_len_i;
    logic [SRC_BITS-1:0] src_sel_i;
    logic [NBEAMS-1:0]   trig_i;
    logic                capture_waiting_i;
    logic                capture_enable_o;
    logic                trig_o;
    logic [NBEAMS-1:0]   trig_beam_o;
    logic [31:0]         trig_count_o;
    logic [SRC_BITS-1:0] src_sel_o;
    logic [2:0]          state_o;

    modport master (
        output arm_i, abort_i, auto_rearm_i, pre_len_i, post_len_i, holdoff_len_i,
               src_sel_i, trig_i, capture_waiting_i,
        input  capture_enable_o, trig_o, trig_beam_o, trig_count_o, src_sel_o, state_o
    );

    modport slave (
        input  arm_i, abort_i, auto_rearm_i, pre_len_i, post_len_i, holdoff_len_i,
               src_sel_i, trig_i, capture_waiting_i,
        output capture_enable_o, trig_o, trig_beam_o, trig_count_o, src_sel_o, state_o
    );
endinterface

// File: rtl/lowampa_capture_ctrl.sv
// Capture sequencer: arm, pretrigger dwell, post window, readout wait, holdoff.
// Define LOWAMPA_SRC_ROTATE_EN to rotate the buffer source after every capture.
module lowampa_capture_ctrl #(
    parameter int NBEAMS   = 2,
    parameter int NSRC     = 4,
    parameter int CNT_BITS = 16
) (
    input logic                   aclk,
    input logic                   reset_i,
    lowampa_capture_ctrl_if.slave bus
);
    localparam int SRC_BITS = $clog2(NSRC);
    localparam logic [CNT_BITS:0] ONE_W = (CNT_BITS+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_POST    = 3'd2,
        S_WAIT    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] pre_len_q, pre_len_d;
    logic [CNT_BITS-1:0] post_len_q, post_len_d;
    logic [CNT_BITS-1:0] hold_len_q, hold_len_d;
    logic [SRC_BITS-1:0] src_q, src_d;
    logic                cap_en_q, cap_en_d;
    logic                trig_q, trig_d;
    logic [NBEAMS-1:0]   beam_q, beam_d;
    logic [31:0]         count_q, count_d;
    logic [CNT_BITS:0]   cnt_inc;
    logic                pre_ok, post_last, hold_last;

    // One shared counter serves pre, post and holdoff; it restarts on every entry.
    assign cnt_inc   = {1'b0, cnt_q} + ONE_W;
    assign pre_ok    = (cnt_q >= pre_len_q);
    assign post_last = (cnt_inc >= {1'b0, post_len_q});
    assign hold_last = (cnt_inc >= {1'b0, hold_len_q});

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pre_len_q  <= '0;
            post_len_q <= '0;
            hold_len_q <= '0;
            src_q      <= '0;
            cap_en_q   <= 1'b0;
            trig_q     <= 1'b0;
            beam_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pre_len_q  <= pre_len_d;
            post_len_q <= post_len_d;
            hold_len_q <= hold_len_d;
            src_q      <= src_d;
            cap_en_q   <= cap_en_d;
            trig_q     <= trig_d;
            beam_q     <= beam_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pre_len_d  = pre_len_q;
        post_len_d = post_len_q;
        hold_len_d = hold_len_q;
        src_d      = src_q;
        cap_en_d   = cap_en_q;
        trig_d     = 1'b0;
        beam_d     = beam_q;
        count_d    = count_q;

        if (bus.abort_i) begin
            state_d  = S_IDLE;
            cap_en_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.arm_i) begin
                        state_d    = S_ARMED;
                        cnt_d      = '0;
                        cap_en_d   = 1'b1;
                        pre_len_d  = bus.pre_len_i;
                        post_len_d = bus.post_len_i;
                        hold_len_d = bus.holdoff_len_i;
                        src_d      = bus.src_sel_i;
                    end
                end
                S_ARMED: begin
                    cap_en_d = 1'b1;
                    if ((bus.trig_i != '0) && pre_ok) begin
                        state_d = S_POST;
                        cnt_d   = '0;
                        trig_d  = 1'b1;
                        beam_d  = bus.trig_i;
                        if (count_q != '1) count_d = count_q + 32'd1;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_inc[CNT_BITS-1:0];
                    end
                end
                S_POST: begin
                    // post_len of 0 still yields a single POST cycle.
                    if (post_last) begin
                        state_d  = S_WAIT;
                        cap_en_d = 1'b0;
`ifdef LOWAMPA_SRC_ROTATE_EN
                        src_d = (src_q == SRC_BITS'(NSRC-1)) ? '0 : src_q + SRC_BITS'(1);
`endif
                    end else begin
                        cnt_d = cnt_inc[CNT_BITS-1:0];
                    end
                end
                S_WAIT: begin
                    if (!bus.capture_waiting_i) begin
                        cnt_d = '0;
                        if (hold_len_q != '0) begin
                            state_d = S_HOLDOFF;
                        end else begin
                            state_d  = bus.auto_rearm_i ? S_ARMED : S_IDLE;
                            cap_en_d = bus.auto_rearm_i;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (hold_last) begin
                        cnt_d    = '0;
                        state_d  = bus.auto_rearm_i ? S_ARMED : S_IDLE;
                        cap_en_d = bus.auto_rearm_i;
                    end else begin
                        cnt_d = cnt_inc[CNT_BITS-1:0];
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    cap_en_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.capture_enable_o = cap_en_q;
    assign bus.trig_o           = trig_q;
    assign bus.trig_beam_o      = beam_q;
    assign bus.trig_count_o     = count_q;
    assign bus.src_sel_o        = src_q;
    assign bus.state_o          = state_q;
endmodule

// File: tb/tb_lowampa_capture_ctrl.sv
// Bench for lowampa_capture_ctrl: directed scenarios plus randomized captures
// checked against a timeline model of each capture.
module tb_lowampa_capture_ctrl;
    localparam int NBEAMS   = 2;
    localparam int NSRC     = 4;
    localparam int CNT_BITS = 16;
    localparam int SRC_BITS = $clog2(NSRC);
    localparam logic [2:0] ST_IDLE = 3'd0, ST_ARMED = 3'd1, ST_POST = 3'd2,
                           ST_WAIT = 3'd3, ST_HOLDOFF = 3'd4;

    logic aclk = 1'b0;
    logic reset_i;
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model state
    int                m_pre, m_post, m_hold;
    int                exp_count;
    int                src_base;
    int                rot_n;
    logic [NBEAMS-1:0] exp_q[$];

    lowampa_capture_ctrl_if #(.NBEAMS(NBEAMS), .NSRC(NSRC), .CNT_BITS(CNT_BITS)) bus ();

    lowampa_capture_ctrl #(.NBEAMS(NBEAMS), .NSRC(NSRC), .CNT_BITS(CNT_BITS)) dut (
        .aclk    (aclk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rotation model: the source advances once per completed post window.
    function automatic logic [31:0] exp_src();
`ifdef LOWAMPA_SRC_ROTATE_EN
        return 32'((src_base + rot_n) % NSRC);
`else
        return 32'(src_base);
`endif
    endfunction

    task automatic arm_cap(input int pre, input int post, input int hold, input int src, input logic auto_r);
        bus.pre_len_i     = CNT_BITS'(pre);
        bus.post_len_i    = CNT_BITS'(post);
        bus.holdoff_len_i = CNT_BITS'(hold);
        bus.src_sel_i     = SRC_BITS'(src);
        bus.auto_rearm_i  = auto_r;
        bus.arm_i         = 1'b1;
        m_pre = pre; m_post = post; m_hold = hold;
        src_base = src; rot_n = 0;
        tick();
        bus.arm_i = 1'b0;
        // Latched values must survive later changes on the inputs.
        bus.pre_len_i     = CNT_BITS'($urandom_range(0, 60));
        bus.post_len_i    = CNT_BITS'($urandom_range(0, 60));
        bus.holdoff_len_i = CNT_BITS'($urandom_range(0, 60));
        bus.src_sel_i     = SRC_BITS'($urandom_range(0, NSRC-1));
        check("arm_state", 32'(bus.state_o), 32'(ST_ARMED));
        check("arm_cap_en", 32'(bus.capture_enable_o), 32'd1);
        check("arm_src", 32'(bus.src_sel_o), exp_src());
    endtask

    // Runs one capture starting at the first ARMED cycle: trigger appears d
    // cycles in, readout stays pending for w WAIT cycles.
    task automatic run_capture(input int d, input logic [NBEAMS-1:0] beam, input int w);
        int k, p;
        k = (m_pre > d) ? m_pre : d;
        p = (m_post == 0) ? 1 : m_post;
        exp_q.push_back(beam);
        for (int i = 0; i <= k; i++) begin
            check("armed_state", 32'(bus.state_o), 32'(ST_ARMED));
            check("armed_trig_o", 32'(bus.trig_o), 32'd0);
            check("armed_cap_en", 32'(bus.capture_enable_o), 32'd1);
            bus.trig_i = (i >= d) ? beam : '0;
            tick();
        end
        exp_count++;
        check("accept_trig_o", 32'(bus.trig_o), 32'd1);
        check("accept_state", 32'(bus.state_o), 32'(ST_POST));
        check("accept_beam", 32'(bus.trig_beam_o), 32'(exp_q.pop_front()));
        check("accept_count", bus.trig_count_o, 32'(exp_count));
        bus.capture_waiting_i = 1'b1;
        for (int j = 0; j < p; j++) begin
            check("post_state", 32'(bus.state_o), 32'(ST_POST));
            check("post_cap_en", 32'(bus.capture_enable_o), 32'd1);
            if (j > 0) check("post_trig_o", 32'(bus.trig_o), 32'd0);
            bus.trig_i = NBEAMS'($urandom_range(0, 3));
            bus.arm_i  = 1'($urandom_range(0, 1));
            tick();
        end
        bus.arm_i  = 1'b0;
        bus.trig_i = '0;
        rot_n++;
        check("wait_state", 32'(bus.state_o), 32'(ST_WAIT));
        check("wait_cap_en", 32'(bus.capture_enable_o), 32'd0);
        check("wait_count", bus.trig_count_o, 32'(exp_count));
        check("wait_src", 32'(bus.src_sel_o), exp_src());
        for (int j = 0; j < w; j++) begin
            tick();
            check("wait_hold", 32'(bus.state_o), 32'(ST_WAIT));
        end
        bus.capture_waiting_i = 1'b0;
        tick();
        for (int j = 0; j < m_hold; j++) begin
            check("holdoff_state", 32'(bus.state_o), 32'(ST_HOLDOFF));
            check("holdoff_cap_en", 32'(bus.capture_enable_o), 32'd0);
            tick();
        end
        check("after_state", 32'(bus.state_o), bus.auto_rearm_i ? 32'(ST_ARMED) : 32'(ST_IDLE));
        check("after_cap_en", 32'(bus.capture_enable_o), 32'(bus.auto_rearm_i));
        check("after_src", 32'(bus.src_sel_o), exp_src());
    endtask

    task automatic abort_now();
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        check("abort_state", 32'(bus.state_o), 32'(ST_IDLE));
        check("abort_cap_en", 32'(bus.capture_enable_o), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(bus.state_o), 32'(ST_IDLE));
        check({tag, "_cap_en"}, 32'(bus.capture_enable_o), 32'd0);
        check({tag, "_trig_o"}, 32'(bus.trig_o), 32'd0);
        check({tag, "_beam"}, 32'(bus.trig_beam_o), 32'd0);
        check({tag, "_count"}, bus.trig_count_o, 32'd0);
        check({tag, "_src"}, 32'(bus.src_sel_o), 32'd0);
    endtask

    initial begin
        logic [SRC_BITS-1:0] rot_tab [3];
        logic in_idle;
`ifdef LOWAMPA_SRC_ROTATE_EN
        rot_tab = '{2'd3, 2'd0, 2'd1};
`else
        rot_tab = '{2'd3, 2'd3, 2'd3};
`endif
        reset_i = 1'b1;
        bus.arm_i = 1'b0; bus.abort_i = 1'b0; bus.auto_rearm_i = 1'b0;
        bus.pre_len_i = '0; bus.post_len_i = '0; bus.holdoff_len_i = '0;
        bus.src_sel_i = '0; bus.trig_i = '0; bus.capture_waiting_i = 1'b0;
        exp_count = 0; src_base = 0; rot_n = 0;

        #3;
        check_reset_values("reset");
        @(posedge aclk);
        @(posedge aclk);
        #1 reset_i = 1'b0;
        tick();
        check("idle_after_reset", 32'(bus.state_o), 32'(ST_IDLE));

        // Pre/post windows: trigger held from first ARMED cycle, pre=4, post=8
        arm_cap(4, 8, 2, 0, 1'b0);
        run_capture(0, 2'b01, 2);

        // Early trigger at pre_cnt=2 is ignored, then abort beats trigger and arm
        arm_cap(4, 3, 0, 1, 1'b0);
        tick();
        tick();
        bus.trig_i = 2'b01;
        tick();
        bus.trig_i = '0;
        for (int i = 0; i < 6; i++) begin
            check("early_trig_o", 32'(bus.trig_o), 32'd0);
            check("early_state", 32'(bus.state_o), 32'(ST_ARMED));
            tick();
        end
        check("early_count", bus.trig_count_o, 32'(exp_count));
        bus.trig_i = 2'b10;
        bus.arm_i  = 1'b1;
        abort_now();
        bus.trig_i = '0;
        bus.arm_i  = 1'b0;
        check("abort_trig_o", 32'(bus.trig_o), 32'd0);
        check("abort_count", bus.trig_count_o, 32'(exp_count));
        tick();
        check("abort_stays_idle", 32'(bus.state_o), 32'(ST_IDLE));

        // Readout wait of 20 cycles, holdoff 3, auto-rearm
        arm_cap(0, 2, 3, 0, 1'b1);
        run_capture(2, 2'b11, 20);
        abort_now();

        // Source rotation across three auto-rearmed captures
        arm_cap(1, 2, 1, 3, 1'b1);
        for (int c = 0; c < 3; c++) begin
            check("rot_src", 32'(bus.src_sel_o), 32'(rot_tab[c]));
            run_capture(c, 2'b10, 1);
        end
        abort_now();

        // Randomized captures
        in_idle = 1'b1;
        for (int it = 0; it < 10; it++) begin
            if (in_idle)
                arm_cap($urandom_range(0, 6), $urandom_range(0, 9), $urandom_range(0, 4),
                        $urandom_range(0, NSRC-1), 1'b0);
            bus.auto_rearm_i = 1'($urandom_range(0, 1));
            run_capture($urandom_range(0, 7), NBEAMS'($urandom_range(1, 3)), $urandom_range(0, 4));
            in_idle = !bus.auto_rearm_i;
        end
        if (!in_idle) abort_now();

        // Asynchronous reset in the middle of POST
        arm_cap(0, 10, 2, 2, 1'b0);
        bus.trig_i = 2'b11;
        tick();
        bus.trig_i = '0;
        check("mid_post_state", 32'(bus.state_o), 32'(ST_POST));
        tick();
        tick();
        #2 reset_i = 1'b1;
        #1;
        check_reset_values("async_reset");
        exp_count = 0;
        exp_q.delete();
        #1 reset_i = 1'b0;
        tick();
        check("post_reset_idle", 32'(bus.state_o), 32'(ST_IDLE));

        // post_len=0 gives a single POST cycle
        arm_cap(2, 0, 1, 0, 1'b1);
        run_capture(1, 2'b10, 0);
        abort_now();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
